// File: rtl/int_pkg.sv
// rtl/int_pkg.sv - shared types and constants for the interrupt controller
// Contents: state enum, intSel write codes, source count, mask reset value,
//           fixed-priority winner function (highest set index wins).
package int_pkg;

    localparam int NUM_SRC = 4;

    // Every source starts masked so nothing fires before software configures vectors.
    localparam logic [NUM_SRC-1:0] MASK_RESET = 4'hF;

    localparam logic [2:0] SEL_VEC0 = 3'd0;
    localparam logic [2:0] SEL_VEC1 = 3'd1;
    localparam logic [2:0] SEL_VEC2 = 3'd2;
    localparam logic [2:0] SEL_VEC3 = 3'd3;
    localparam logic [2:0] SEL_MASK = 3'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    // Ascending scan so the last (highest) set bit overwrites lower ones.
    function automatic logic [1:0] pick_winner(input logic [NUM_SRC-1:0] elig);
        logic [1:0] w;
        w = 2'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (elig[i]) w = 2'(i);
        end
        return w;
    endfunction

endpackage

// File: rtl/int_controller_if.sv
// rtl/int_controller_if.sv - pin, config and datapath handshake bundle
// Signals: int0..int3 (async request pins), intWrite/intSel/intDataIn (config port),
//          intAck/intDone (datapath handshake), intr/intLvl/intVec/busy (controller outputs).
// intLvl[1] is the datapath's intLvl1 line, intLvl[0] is intLvl0.
// Modports: master = board/datapath side, slave = controller.
interface int_controller_if #(
    parameter int DATA_W = 16
);
    logic              int0;
    logic              int1;
    logic              int2;
    logic              int3;
    logic              intWrite;
    logic [2:0]        intSel;
    logic [DATA_W-1:0] intDataIn;
    logic              intAck;
    logic              intDone;
    logic              intr;
    logic [1:0]        intLvl;
    logic [DATA_W-1:0] intVec;
    logic              busy;

    modport master (
        output int0, int1, int2, int3,
        output intWrite, intSel, intDataIn,
        output intAck, intDone,
        input  intr, intLvl, intVec, busy
    );

    modport slave (
        input  int0, int1, int2, int3,
        input  intWrite, intSel, intDataIn,
        input  intAck, intDone,
        output intr, intLvl, intVec, busy
    );
endinterface

// File: rtl/int_sync_edge.sv
// rtl/int_sync_edge.sv - multi-flop synchroniser followed by a rising-edge detector
// Ports: clk, rst_n (async active-low), din (asynchronous pin), rise (one-cycle pulse
//        on a synchronised 0->1 transition).
module int_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/int_controller.sv
// rtl/int_controller.sv - four-source fixed-priority interrupt controller
// Ports: CLK, Reset_n (async active-low), bus (int_controller_if.slave).
// Pins are synchronised and edge-detected into pending bits, masked, and the
// highest eligible index is granted via registered intr/intLvl/intVec, then the
// intAck / intDone handshake returns the FSM (IDLE -> REQ -> SERVICE) to IDLE.
// Build option: define INT_NEST_EN to let a higher source preempt SERVICE,
// saving the interrupted level on a 4-entry stack that intDone pops.
module int_controller
    import int_pkg::*;
#(
    parameter int                DATA_W      = 16,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] RESET_VEC   = 16'h0000
) (
    input  logic               CLK,
    input  logic               Reset_n,
    int_controller_if.slave    bus
);

    logic [NUM_SRC-1:0] pins, edges, eligible;
    logic [1:0]         winner;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [DATA_W-1:0]  vec_q [NUM_SRC];
    logic [DATA_W-1:0]  vec_d [NUM_SRC];
    logic               intr_q, intr_d;
    logic [1:0]         lvl_q, lvl_d;
    logic [DATA_W-1:0]  intvec_q, intvec_d;

`ifdef INT_NEST_EN
    logic [1:0]         stk_lvl_q [4];
    logic [1:0]         stk_lvl_d [4];
    logic [DATA_W-1:0]  stk_vec_q [4];
    logic [DATA_W-1:0]  stk_vec_d [4];
    logic [2:0]         sp_q, sp_d;
    logic [1:0]         sp_top;
    logic               preempt;

    assign sp_top  = sp_q[1:0] - 2'd1;
    assign preempt = (|eligible) && (winner > lvl_q);
`endif

    assign pins = {bus.int3, bus.int2, bus.int1, bus.int0};

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
        int_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk   (CLK),
            .rst_n (Reset_n),
            .din   (pins[i]),
            .rise  (edges[i])
        );
    end

    assign eligible = pending_q & ~mask_q;
    assign winner   = pick_winner(eligible);

    // State register (plus all datapath registers)
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            mask_q    <= MASK_RESET;
            for (int i = 0; i < NUM_SRC; i++) vec_q[i] <= RESET_VEC;
            intr_q    <= 1'b0;
            lvl_q     <= 2'd0;
            intvec_q  <= '0;
`ifdef INT_NEST_EN
            sp_q      <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                stk_lvl_q[i] <= 2'd0;
                stk_vec_q[i] <= '0;
            end
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            vec_q     <= vec_d;
            intr_q    <= intr_d;
            lvl_q     <= lvl_d;
            intvec_q  <= intvec_d;
`ifdef INT_NEST_EN
            sp_q      <= sp_d;
            stk_lvl_q <= stk_lvl_d;
            stk_vec_q <= stk_vec_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|eligible) state_d = REQ;
            REQ:     if (bus.intAck) state_d = SERVICE;
            SERVICE: begin
`ifdef INT_NEST_EN
                if (bus.intDone)  state_d = (sp_q == 3'd0) ? IDLE : SERVICE;
                else if (preempt) state_d = REQ;
`else
                if (bus.intDone)  state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath logic; reads only pre-write mask/vector values so a
    // config write landing with a grant does not affect that grant.
    always_comb begin
        pending_d = pending_q | edges;
        mask_d    = mask_q;
        vec_d     = vec_q;
        intr_d    = intr_q;
        lvl_d     = lvl_q;
        intvec_d  = intvec_q;
`ifdef INT_NEST_EN
        sp_d      = sp_q;
        stk_lvl_d = stk_lvl_q;
        stk_vec_d = stk_vec_q;
`endif

        if (bus.intWrite) begin
            case (bus.intSel)
                SEL_VEC0, SEL_VEC1, SEL_VEC2, SEL_VEC3: vec_d[bus.intSel[1:0]] = bus.intDataIn;
                SEL_MASK: mask_d = bus.intDataIn[NUM_SRC-1:0];
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    intr_d   = 1'b1;
                    lvl_d    = winner;
                    intvec_d = vec_q[winner];
                end
            end
            REQ: begin
                if (bus.intAck) begin
                    intr_d = 1'b0;
                    // A fresh edge on the granted source in the ack cycle must survive.
                    pending_d[lvl_q] = edges[lvl_q];
                end
            end
            SERVICE: begin
`ifdef INT_NEST_EN
                if (bus.intDone) begin
                    if (sp_q != 3'd0) begin
                        sp_d     = sp_q - 3'd1;
                        lvl_d    = stk_lvl_q[sp_top];
                        intvec_d = stk_vec_q[sp_top];
                    end
                end else if (preempt) begin
                    stk_lvl_d[sp_q[1:0]] = lvl_q;
                    stk_vec_d[sp_q[1:0]] = intvec_q;
                    sp_d     = sp_q + 3'd1;
                    intr_d   = 1'b1;
                    lvl_d    = winner;
                    intvec_d = vec_q[winner];
                end
`endif
            end
            default: ;
        endcase
    end

    assign bus.intr   = intr_q;
    assign bus.intLvl = lvl_q;
    assign bus.intVec = intvec_q;
    assign bus.busy   = (state_q != IDLE);

endmodule
